// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned ANCHO_DEF = 8;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} estado_e;

  // Counter must reach ANCHO, so it needs clog2(ANCHO+1) bits.
  function automatic int unsigned cnt_ancho(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_ancho(ANCHO_DEF);

endpackage

// File: rtl/paso_division.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module paso_division #(
  parameter int unsigned ANCHO = 8
) (
  input  logic [ANCHO-1:0] rem_i,
  input  logic             bit_i,
  input  logic [ANCHO-1:0] divisor_i,
  output logic [ANCHO-1:0] rem_o,
  output logic             q_o
);

  logic [ANCHO:0] desp;
  logic [ANCHO:0] dif;

  // rem_i < divisor, so either result fits back into ANCHO bits.
  always_comb begin
    desp  = {rem_i, bit_i};
    dif   = desp - {1'b0, divisor_i};
    q_o   = ~dif[ANCHO];
    rem_o = q_o ? dif[ANCHO-1:0] : desp[ANCHO-1:0];
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider with start/done/ack handshake, one quotient bit per clock.
// Define DIVISOR_SIGNO_EN for two's-complement operands (truncating division).
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicio,
  input  logic [ANCHO-1:0] dividendo,
  input  logic [ANCHO-1:0] divisor,
  input  logic             listoS,
  output logic             ocupado,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             divisionLista,
  output logic             errorDivCero
);

  localparam int unsigned CntW = cnt_ancho(ANCHO);

  estado_e          estado_q;
  logic [ANCHO-1:0] dvd_q, dsr_q, rem_q;
  logic [ANCHO-1:0] cociente_q, residuo_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q;

  logic [ANCHO-1:0] rem_d, quo_d;
  logic             qbit;
  logic [ANCHO-1:0] quo_fin, rem_fin;
  logic [ANCHO-1:0] mag_dvd, mag_dsr;

  paso_division #(.ANCHO(ANCHO)) u_paso (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[ANCHO-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .q_o       (qbit)
  );

  // The dividend register doubles as the quotient shift register.
  assign quo_d = {dvd_q[ANCHO-2:0], qbit};

`ifdef DIVISOR_SIGNO_EN
  logic neg_q, rneg_q;

  assign mag_dvd = dividendo[ANCHO-1] ? -dividendo : dividendo;
  assign mag_dsr = divisor[ANCHO-1] ? -divisor : divisor;
  assign quo_fin = neg_q ? -quo_d : quo_d;
  assign rem_fin = rneg_q ? -rem_d : rem_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (estado_q == StIdle && inicio) begin
      neg_q  <= dividendo[ANCHO-1] ^ divisor[ANCHO-1];
      rneg_q <= dividendo[ANCHO-1];
    end
  end
`else
  assign mag_dvd = dividendo;
  assign mag_dsr = divisor;
  assign quo_fin = quo_d;
  assign rem_fin = rem_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= StIdle;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          if (inicio) begin
            dvd_q <= mag_dvd;
            dsr_q <= mag_dsr;
            rem_q <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              cociente_q <= '1;
              residuo_q  <= dividendo;
              err_q      <= 1'b1;
              estado_q   <= StDone;
            end else begin
              estado_q <= StCalc;
            end
          end
        end
        StCalc: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(ANCHO - 1)) begin
            cociente_q <= quo_fin;
            residuo_q  <= rem_fin;
            estado_q   <= StDone;
          end
        end
        StDone: begin
          if (listoS) begin
            err_q    <= 1'b0;
            estado_q <= StIdle;
          end
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

  assign ocupado       = (estado_q != StIdle);
  assign divisionLista = (estado_q == StDone);
  assign cociente      = cociente_q;
  assign residuo       = residuo_q;
  assign errorDivCero  = err_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: fixed vector table, handshake corner cases, random ops vs. arithmetic model.
module tb_divisor_secuencial;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inicio = 1'b0;
  logic [W-1:0] dividendo = '0;
  logic [W-1:0] divisor = '0;
  logic         listoS = 1'b0;
  logic         ocupado;
  logic [W-1:0] cociente;
  logic [W-1:0] residuo;
  logic         divisionLista;
  logic         errorDivCero;

  int n_vec = 0;
  int n_err = 0;
  int ciclo = 0;
  int t0 = 0;

  divisor_secuencial #(.ANCHO(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .inicio        (inicio),
    .dividendo     (dividendo),
    .divisor       (divisor),
    .listoS        (listoS),
    .ocupado       (ocupado),
    .cociente      (cociente),
    .residuo       (residuo),
    .divisionLista (divisionLista),
    .errorDivCero  (errorDivCero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
  } vec_t;

  vec_t tabla[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in the signed build.
  function automatic void modelo(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic e);
    int sa, sb, iq, ir;
    if (b == 0) begin
      q = '1;
      r = a;
      e = 1'b1;
    end else begin
`ifdef DIVISOR_SIGNO_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      iq = sa / sb;
      ir = sa % sb;
      q = iq[W-1:0];
      r = ir[W-1:0];
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    dividendo = a;
    divisor   = b;
    inicio    = 1'b1;
    @(posedge clock);
    #1;
    inicio = 1'b0;
    t0 = ciclo;
  endtask

  task automatic wait_done(input int exp_lat);
    while (!divisionLista && (ciclo - t0) < 30) begin
      @(posedge clock);
      #1;
    end
    chk("latencia", ciclo - t0, exp_lat);
  endtask

  task automatic check_res(input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
    chk("cociente", int'(cociente), int'(q));
    chk("residuo", int'(residuo), int'(r));
    chk("errorDivCero", int'(errorDivCero), int'(e));
    chk("ocupado_done", int'(ocupado), 1);
  endtask

  task automatic ack(input logic [W-1:0] q);
    @(negedge clock);
    listoS = 1'b1;
    @(posedge clock);
    #1;
    listoS = 1'b0;
    chk("lista_tras_ack", int'(divisionLista), 0);
    chk("err_tras_ack", int'(errorDivCero), 0);
    chk("ocupado_tras_ack", int'(ocupado), 0);
    chk("cociente_retenido", int'(cociente), int'(q));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
    start_op(a, b);
    wait_done(e ? 0 : W);
    check_res(q, r, e);
    ack(q);
  endtask

  logic [W-1:0] mq, mr;
  logic         me;

  initial begin
`ifdef DIVISOR_SIGNO_EN
    tabla[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
    tabla[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0};
    tabla[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0};
    tabla[3] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0};
    tabla[4] = '{8'd0,   8'd9,   8'h00, 8'h00, 1'b0};
    tabla[5] = '{8'd37,  8'd0,   8'hFF, 8'd37, 1'b1};
`else
    tabla[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tabla[1] = '{8'd7,   8'd100, 8'd0,   8'd7,  1'b0};
    tabla[2] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tabla[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tabla[4] = '{8'd0,   8'd9,   8'd0,   8'd0,  1'b0};
    tabla[5] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1};
`endif

    #1;
    chk("rst_cociente", int'(cociente), 0);
    chk("rst_residuo", int'(residuo), 0);
    chk("rst_lista", int'(divisionLista), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tabla[i]) do_op(tabla[i].a, tabla[i].b, tabla[i].q, tabla[i].r, tabla[i].e);

    // Result must hold while the consumer stalls.
    modelo(8'd100, 8'd7, mq, mr, me);
    start_op(8'd100, 8'd7);
    wait_done(W);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      chk("hold_lista", int'(divisionLista), 1);
      chk("hold_cociente", int'(cociente), int'(mq));
      chk("hold_residuo", int'(residuo), int'(mr));
    end
    ack(mq);

    // inicio during CALC/DONE and operand changes must not disturb the result.
    start_op(8'd100, 8'd7);
    @(negedge clock);
    @(negedge clock);
    inicio    = 1'b1;
    dividendo = 8'd50;
    divisor   = 8'd5;
    @(negedge clock);
    inicio    = 1'b0;
    dividendo = 8'd11;
    divisor   = 8'd0;
    wait_done(W);
    check_res(mq, mr, me);
    @(negedge clock);
    inicio    = 1'b1;
    dividendo = 8'd9;
    divisor   = 8'd3;
    @(posedge clock);
    #1;
    chk("done_ignora_inicio", int'(cociente), int'(mq));
    chk("done_sigue_lista", int'(divisionLista), 1);
    @(negedge clock);
    listoS = 1'b1;
    @(posedge clock);
    #1;
    chk("ack_con_inicio_ocupado", int'(ocupado), 0);
    @(negedge clock);
    inicio = 1'b0;
    listoS = 1'b0;
    @(posedge clock);
    #1;
    chk("sin_segunda_op", int'(ocupado), 0);

    // Asynchronous reset between edges, mid-calculation.
    start_op(8'd100, 8'd7);
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cociente", int'(cociente), 0);
    chk("arst_residuo", int'(residuo), 0);
    chk("arst_lista", int'(divisionLista), 0);
    chk("arst_err", int'(errorDivCero), 0);
    chk("arst_ocupado", int'(ocupado), 0);
    @(negedge clock);
    reset = 1'b0;
    modelo(8'd200, 8'd3, mq, mr, me);
    do_op(8'd200, 8'd3, mq, mr, me);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = (i % 10 == 3) ? '0 : W'($urandom_range(0, 255));
      modelo(ra, rb, mq, mr, me);
      do_op(ra, rb, mq, mr, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
